note_tone_gen: RTL
==================

# note_tone_gen

Square-wave audio generator that consumes the 20-bit half-period divider produced by the note-selection logic. It turns that divider into a 50%-duty tone, scales it by a 3-bit volume, and drives signed 16-bit PCM samples to the left/right audio channels. It sits between note selection and the audio DAC/serializer, all in the 40 MHz system clock domain.

## Interface

- DIV_WIDTH, 20, width of the note divider (half-period length in clocks).
- AMP_WIDTH, 16, width of each signed PCM output sample.
- clk  in  1  system clock, 40 MHz; all logic on the rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on the rising edge of clk.
- note_div  in  DIV_WIDTH  half-period length in clk cycles; 0 means silence. Example: 38168 gives ~524 Hz, 76628 gives ~261 Hz.
- vol  in  3  volume level 0..7.
- mute  in  1  forces both audio outputs to 0 while high; the tone keeps running.
- audio_left  out  AMP_WIDTH  signed two's-complement PCM sample.
- audio_right  out  AMP_WIDTH  identical to audio_left.
- tone_sq  out  1  raw square wave (the current phase bit).
- note_active  out  1  high while in RUN.
- period_tick  out  1  one-cycle pulse when a full period completes.

## Operation

- Registers:
  - state (IDLE/RUN)
  - cnt[DIV_WIDTH-1:0]
  - active_div[DIV_WIDTH-1:0]
  - phase
- All outputs are registered.
- IDLE:
  - cnt=0, phase=0.
  - When note_div != 0 is sampled: active_div<=note_div, cnt<=0, phase<=0, go to RUN.
- RUN, when note_div == 0 is sampled: stop immediately.
  - Next cycle: state=IDLE, cnt=0, phase=0.
  - Outputs go to 0 and period_tick stays 0.
  - Zero takes priority over every other RUN action.
- RUN, when cnt == active_div-1 (half-period boundary):
  - cnt<=0 and phase<=~phase.
  - active_div<=note_div, so a new pitch is applied only at a boundary (glitch-free).
  - If phase was 1, period_tick<=1 for that one cycle.
- RUN, all other cycles: cnt<=cnt+1. A note_div change (nonzero to nonzero) is ignored until the next boundary.
- Each phase therefore lasts exactly active_div clocks. note_div=1 toggles every cycle. The full period is 2*active_div clocks.
- Amplitude: amp = {1'b0, vol, 12'h000}, giving 0..0x7000. vol is sampled every cycle and is not synchronized to the boundary.
- Sample value:
  - In RUN: phase=1 gives +amp, phase=0 gives -amp (two's complement; vol=7 gives 0x7000 / 0x9000).
  - IDLE, mute=1, or vol=0 gives 0x0000.
- Outputs: audio_right = audio_left; tone_sq = phase; note_active = (state==RUN).
- Reset values: state=IDLE, cnt=0, active_div=0, phase=0. All outputs 0 (audio_left=audio_right=0x0000, tone_sq=0, note_active=0, period_tick=0).

## Timing

- Start latency: note_div sampled nonzero at edge N gives note_active=1, tone_sq=0 and audio=-amp after edge N+1.
- Following the start, the first toggle is at edge N+1+active_div.
- Stop latency: note_div sampled 0 at edge M gives outputs 0 after edge M+1.
- vol and mute reach audio on the edge after they are sampled (1 cycle).
- period_tick is high in the same cycle in which tone_sq falls 1->0.
- Reset mid-tone: on the reset edge all state and outputs clear. On the first edge with rst_n=1, IDLE behaviour resumes (start latency as above).
- Simultaneous events at a boundary:
  - note_div==0 wins; the block goes IDLE and no toggle or tick occurs.
  - A nonzero change loads together with the toggle.

## Test plan

- Reset: assert rst_n=0 for 3 cycles while note_div=4 and vol=7 -> all outputs 0. After release, the first sample is 0x9000 one cycle after rst_n samples high.
- Basic tone: note_div=4, vol=7, mute=0 -> audio repeats 4 cycles of 0x9000 then 4 cycles of 0x7000. tone_sq matches. period_tick pulses every 8 cycles, aligned with each 0x7000->0x9000 transition.
- Pitch change mid-phase: note_div=6 running; switch to 2 at cnt=1 -> the current phase still lasts 6 cycles, then phases of 2 cycles follow.
- Silence: note_div drops to 0 mid-phase -> next cycle audio=0, note_active=0, no period_tick. Restoring note_div=3 -> restart with phase 0 (0x9000 at vol=7) for 3 cycles.
- Volume/mute: note_div=38168 with vol stepped 7->1->0 -> peak magnitude 0x7000 -> 0x1000 -> 0. mute=1 -> audio 0 while tone_sq keeps toggling every 38168 cycles.
- Minimum divider: note_div=1, vol=2 -> audio alternates 0xE000/0x2000 every cycle and period_tick pulses every 2 cycles.

Source files
------------

// File: rtl/note_tone_gen.sv
// Square-wave tone generator: turns a half-period divider into a
// 50%-duty tone scaled by volume, driven as signed PCM on both channels.
module note_tone_gen #(
  parameter int DIV_WIDTH = 20,
  parameter int AMP_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DIV_WIDTH-1:0] note_div,
  input  logic [2:0]           vol,
  input  logic                 mute,
  output logic [AMP_WIDTH-1:0] audio_left,
  output logic [AMP_WIDTH-1:0] audio_right,
  output logic                 tone_sq,
  output logic                 note_active,
  output logic                 period_tick
);

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic                 phase_q, phase_d;
  logic                 tick_q, tick_d;
  logic [AMP_WIDTH-1:0] smp_q, smp_d;
  logic [AMP_WIDTH-1:0] amp;
  logic                 zero_div;
  logic                 at_edge;

  assign zero_div = (note_div == '0);
  assign at_edge  = (cnt_q == div_q - DIV_WIDTH'(1));
  assign amp      = AMP_WIDTH'({vol, 12'h000});

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    phase_d = phase_q;
    tick_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        phase_d = 1'b0;
        if (!zero_div) begin
          div_d   = note_div;
          state_d = RUN;
        end
      end
      RUN: begin
        // silence beats any boundary action
        if (zero_div) begin
          state_d = IDLE;
          cnt_d   = '0;
          phase_d = 1'b0;
        end else if (at_edge) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
          div_d   = note_div;
          tick_d  = phase_q;
        end else begin
          cnt_d = cnt_q + DIV_WIDTH'(1);
        end
      end
    endcase
    smp_d = '0;
    if (state_d == RUN && !mute) begin
      smp_d = phase_d ? amp : -amp;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      phase_q <= 1'b0;
      tick_q  <= 1'b0;
      smp_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      tick_q  <= tick_d;
      smp_q   <= smp_d;
    end
  end

  assign audio_left  = smp_q;
  assign audio_right = smp_q;
  assign tone_sq     = phase_q;
  assign note_active = (state_q == RUN);
  assign period_tick = tick_q;

endmodule
